mem_stage_pipe: RTL and testbench
=================================

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 32: width of ALU result, memory data and writeback result.
REQ-002 Parameter ADDR_W, default 20: word address width per bank.
REQ-003 Parameter RD_W, default 7: destination register index width.
REQ-004 Parameter BANKS, default 2, range 1..8: number of data-memory banks; BANK_W = max(1, clog2(BANKS)).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both are high at a clock edge.
REQ-008 opcode  in  5  operation: 0 NOP, 1 LV, 2-5 ALU, 6 CP (load), 9 SLR, 10 GP (store); all others reserved.
REQ-009 alu_result, mem_addr_in, store_data  in  DATA_W each  ALU value, memory address operand, store value.
REQ-010 rd_alu, rd_mem  in  RD_W each  destination for ALU ops and for CP respectively.
REQ-011 branch_in  in  RD_W  branch result forwarded to writeback.
REQ-012 mem_req, mem_we  out  1 each  memory request and write strobe.
REQ-013 mem_bank, mem_addr, mem_wdata  out  BANK_W / ADDR_W / DATA_W  memory request fields.
REQ-014 mem_ack, mem_rdata  in  1 / DATA_W  memory completion and read data.
REQ-015 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-016 wb_result, wb_rd, wb_we, branch_out  out  DATA_W / RD_W / 1 / RD_W  writeback bundle.

Function
REQ-017 FSM states SHALL be IDLE, MEM and OUT; in_ready SHALL be 1 only in IDLE.
REQ-018 On accept of CP: mem_req=1, mem_we=0, mem_addr=mem_addr_in[ADDR_W-1:0], mem_bank=mem_addr_in[ADDR_W +: BANK_W] (0 if BANKS=1); next state MEM.
REQ-019 On accept of GP: as CP, but mem_we=1 and mem_wdata=store_data; next state MEM.
REQ-020 On accept of any other opcode: wb_result=alu_result, wb_rd=rd_alu, wb_we=1 for opcodes 1-5 and 9 and 0 otherwise; next state OUT.
REQ-021 In MEM, all mem_* outputs SHALL stay stable until the edge at which mem_ack=1.
REQ-022 On that edge: mem_req drops; CP loads wb_result=mem_rdata, wb_rd=rd_mem, wb_we=1; GP loads wb_result=store_data, wb_rd=rd_mem, wb_we=0; next state OUT.
REQ-023 mem_ack is ignored outside MEM; mem_ack high on the first MEM cycle completes the access in that cycle.
REQ-024 In OUT, out_valid=1 and the bundle holds until out_ready=1; that edge returns the FSM to IDLE.
REQ-025 Latency: a non-memory op accepted at edge N gives out_valid after edge N; a memory op acked at edge M gives out_valid after edge M.
REQ-026 branch_out SHALL be branch_in captured at accept and SHALL read 0 whenever out_valid=0.
REQ-027 Out-of-range bank values (>= BANKS) are issued unchanged; the memory system decodes them.

Reset
REQ-028 While rst=1, state=IDLE and mem_req, mem_we, out_valid and wb_we are 0; all data outputs and mem_addr, mem_bank and mem_wdata are 0.
REQ-029 Reset during MEM SHALL abandon the access immediately; an ack arriving after reset release is ignored.

Configuration
REQ-030 With MEM_STAGE_STATS_EN defined, a 16-bit output stall_cnt SHALL count cycles spent in MEM or in OUT with out_ready=0; it saturates at 0xFFFF and is cleared by rst.
REQ-031 Without MEM_STAGE_STATS_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Send ADD (op 2, alu_result=0x1234, rd_alu=5) with out_ready=1 -> out_valid one cycle later; wb_result=0x1234, wb_rd=5, wb_we=1.
REQ-033 Send CP with mem_addr_in=0x0010_0004 (BANKS=2), ack after 3 cycles with rdata=0xCAFE -> mem_bank=1, mem_addr=0x00004; wb_result=0xCAFE, wb_rd=rd_mem, wb_we=1.
REQ-034 Send GP with store_data=0xBEEF -> mem_we=1 and mem_wdata=0xBEEF held until ack; resulting writeback has wb_we=0.
REQ-035 Hold out_ready=0 for 4 cycles after a result -> bundle stable, in_ready=0, stall_cnt increments by 4 (with the macro defined).
REQ-036 Assert rst mid-MEM, then ack after release -> mem_req=0 immediately, FSM in IDLE, no out_valid produced.
REQ-037 Send reserved opcode 7 -> wb_we=0, out_valid pulses, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_stage_pipe_if.sv
// Bundle of the memory-stage handshake, memory request and writeback signals.
// The master side is the environment (upstream, memory and downstream); the slave side is the stage.
interface mem_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20,
  parameter int RD_W   = 7,
  parameter int BANKS  = 2
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        opcode;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_addr_in;
  logic [DATA_W-1:0] store_data;
  logic [RD_W-1:0]   rd_alu;
  logic [RD_W-1:0]   rd_mem;
  logic [RD_W-1:0]   branch_in;
  logic              mem_req;
  logic              mem_we;
  logic [BANK_W-1:0] mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] wb_result;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_we;
  logic [RD_W-1:0]   branch_out;

  modport master (
    output in_valid, opcode, alu_result, mem_addr_in, store_data, rd_alu, rd_mem, branch_in,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_bank, mem_addr, mem_wdata,
    input  out_valid, wb_result, wb_rd, wb_we, branch_out
  );

  modport slave (
    input  in_valid, opcode, alu_result, mem_addr_in, store_data, rd_alu, rd_mem, branch_in,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_bank, mem_addr, mem_wdata,
    output out_valid, wb_result, wb_rd, wb_we, branch_out
  );
endinterface

// File: rtl/mem_stage_pipe.sv
// Memory stage: issues CP/GP accesses to a banked data memory and forms the writeback bundle.
// Optional MEM_STAGE_STATS_EN adds a saturating 16-bit stall_cnt output.
module mem_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20,
  parameter int RD_W   = 7,
  parameter int BANKS  = 2
) (
  input  logic clk,
  input  logic rst,
  mem_stage_pipe_if.slave bus
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  localparam logic [4:0] OP_CP = 5'd6;
  localparam logic [4:0] OP_GP = 5'd10;
  localparam logic [4:0] OP_SLR = 5'd9;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, OUT = 2'd2} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              is_mem_op;
  logic              is_wb_op;
  logic [BANK_W-1:0] bank_sel;
  logic              mem_we_r;
  logic [BANK_W-1:0] mem_bank_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] wb_result_r;
  logic [RD_W-1:0]   wb_rd_r;
  logic              wb_we_r;
  logic [RD_W-1:0]   branch_r;

  // Opcode classification and bank extraction from the incoming address
  always_comb begin
    is_mem_op = (bus.opcode == OP_CP) || (bus.opcode == OP_GP);
    is_wb_op  = ((bus.opcode >= 5'd1) && (bus.opcode <= 5'd5)) || (bus.opcode == OP_SLR);
    if (BANKS > 1) begin
      bank_sel = bus.mem_addr_in[ADDR_W +: BANK_W];
    end else begin
      bank_sel = '0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = is_mem_op ? MEM : OUT;
        end else begin
          state_nxt = IDLE;
        end
      end
      MEM: begin
        if (bus.mem_ack) begin
          state_nxt = OUT;
        end else begin
          state_nxt = MEM;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OUT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request and writeback registers, loaded at accept and at memory completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we_r    <= 1'b0;
      mem_bank_r  <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      wb_result_r <= '0;
      wb_rd_r     <= '0;
      wb_we_r     <= 1'b0;
      branch_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            branch_r <= bus.branch_in;
            if (is_mem_op) begin
              mem_we_r   <= (bus.opcode == OP_GP);
              mem_addr_r <= bus.mem_addr_in[ADDR_W-1:0];
              mem_bank_r <= bank_sel;
              if (bus.opcode == OP_GP) begin
                mem_wdata_r <= bus.store_data;
              end
              wb_rd_r <= bus.rd_mem;
              wb_we_r <= 1'b0;
            end else begin
              wb_result_r <= bus.alu_result;
              wb_rd_r     <= bus.rd_alu;
              wb_we_r     <= is_wb_op;
            end
          end
        end
        MEM: begin
          // A store writes back its own data but never the register file
          if (bus.mem_ack) begin
            wb_result_r <= mem_we_r ? mem_wdata_r : bus.mem_rdata;
            wb_we_r     <= ~mem_we_r;
          end
        end
        OUT: ;
        default: ;
      endcase
    end
  end

  // Output decode from state and held registers
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.mem_req    = (state == MEM);
    bus.mem_we     = (state == MEM) && mem_we_r;
    bus.mem_bank   = mem_bank_r;
    bus.mem_addr   = mem_addr_r;
    bus.mem_wdata  = mem_wdata_r;
    bus.out_valid  = (state == OUT);
    bus.wb_result  = wb_result_r;
    bus.wb_rd      = wb_rd_r;
    bus.wb_we      = wb_we_r;
    bus.branch_out = (state == OUT) ? branch_r : '0;
  end

`ifdef MEM_STAGE_STATS_EN
  logic [15:0] stall_r;

  // Saturating count of cycles waiting on memory or on the downstream stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= 16'd0;
    end else if (((state == MEM) || ((state == OUT) && !bus.out_ready)) && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`endif
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Randomized self-checking bench for mem_stage_pipe with a transaction-level expectation model.
module tb_mem_stage_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 20;
  localparam int RD_W   = 7;
  localparam int BANKS  = 2;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   chk_en;

  mem_stage_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .BANKS(BANKS)) bus ();

`ifdef MEM_STAGE_STATS_EN
  logic [15:0] stall_cnt;
  mem_stage_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .BANKS(BANKS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  mem_stage_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .BANKS(BANKS)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  // Expected view of the outputs, updated by the driver right after each edge
  logic              e_in_ready, e_out_valid, e_mem_req, e_mem_we, e_wb_we;
  logic [BANK_W-1:0] e_mem_bank;
  logic [ADDR_W-1:0] e_mem_addr;
  logic [DATA_W-1:0] e_mem_wdata, e_wb_result;
  logic [RD_W-1:0]   e_wb_rd, e_branch;
  int                e_stall;

  // Current transaction as seen at accept
  logic [4:0]        m_op;
  logic [DATA_W-1:0] m_sd;
  logic [RD_W-1:0]   m_rdm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(e_in_ready));
      check("out_valid", 64'(bus.out_valid), 64'(e_out_valid));
      check("mem_req", 64'(bus.mem_req), 64'(e_mem_req));
      check("mem_we", 64'(bus.mem_we), 64'(e_mem_we));
      if (e_mem_req) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(e_mem_addr));
        check("mem_bank", 64'(bus.mem_bank), 64'(e_mem_bank));
        if (e_mem_we) check("mem_wdata", 64'(bus.mem_wdata), 64'(e_mem_wdata));
      end
      if (e_out_valid) begin
        check("wb_result", 64'(bus.wb_result), 64'(e_wb_result));
        check("wb_rd", 64'(bus.wb_rd), 64'(e_wb_rd));
        check("wb_we", 64'(bus.wb_we), 64'(e_wb_we));
      end
      check("branch_out", 64'(bus.branch_out), e_out_valid ? 64'(e_branch) : 64'd0);
`ifdef MEM_STAGE_STATS_EN
      check("stall_cnt", 64'(stall_cnt), 64'(e_stall > 65535 ? 65535 : e_stall));
`endif
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_mem_req"}, 64'(bus.mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_wb_we"}, 64'(bus.wb_we), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, "_data"}, {bus.wb_result, 25'(bus.wb_rd), 7'(bus.branch_out)}, 64'd0);
    check({tag, "_memf"}, {bus.mem_wdata, 11'(bus.mem_addr), 21'(bus.mem_bank)}, 64'd0);
`ifdef MEM_STAGE_STATS_EN
    check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  task automatic set_idle();
    e_in_ready = 1'b1; e_out_valid = 1'b0; e_mem_req = 1'b0; e_mem_we = 1'b0;
  endtask

  task automatic scramble();
    bus.opcode      = 5'($urandom);
    bus.alu_result  = $urandom;
    bus.mem_addr_in = $urandom;
    bus.store_data  = $urandom;
    bus.rd_alu      = 7'($urandom);
    bus.rd_mem      = 7'($urandom);
    bus.branch_in   = 7'($urandom);
    bus.mem_rdata   = $urandom;
  endtask

  // Present one instruction in IDLE and advance past the accept edge
  task automatic accept(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [6:0] rda, input logic [6:0] rdm,
                        input logic [6:0] br);
    bus.in_valid = 1'b1; bus.opcode = op; bus.alu_result = alu; bus.mem_addr_in = addr;
    bus.store_data = sd; bus.rd_alu = rda; bus.rd_mem = rdm; bus.branch_in = br;
    bus.mem_ack = 1'($urandom);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    m_op = op; m_sd = sd; m_rdm = rdm;
    e_in_ready = 1'b0;
    e_branch   = br;
    if (op == 5'd6 || op == 5'd10) begin
      e_mem_req  = 1'b1;
      e_mem_we   = (op == 5'd10);
      e_mem_addr = addr[ADDR_W-1:0];
      e_mem_bank = addr[ADDR_W +: BANK_W];
      if (op == 5'd10) e_mem_wdata = sd;
      bus.mem_ack = 1'b0;
    end else begin
      e_out_valid = 1'b1;
      e_wb_result = alu;
      e_wb_rd     = rda;
      e_wb_we     = ((op >= 5'd1) && (op <= 5'd5)) || (op == 5'd9);
    end
  endtask

  // Hold the access for 'dly' cycles, then acknowledge with rdata
  task automatic mem_phase(input int dly, input logic [31:0] rdata);
    for (int i = 0; i < dly; i++) begin
      bus.mem_ack = 1'b0; bus.in_valid = 1'($urandom);
      @(posedge clk); #1;
      e_stall++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata; bus.in_valid = 1'($urandom);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.in_valid = 1'b0; scramble();
    e_stall++;
    e_mem_req   = 1'b0;
    e_mem_we    = 1'b0;
    e_out_valid = 1'b1;
    e_wb_result = (m_op == 5'd6) ? rdata : m_sd;
    e_wb_rd     = m_rdm;
    e_wb_we     = (m_op == 5'd6);
  endtask

  // Stall the consumer for 'stall' cycles, then retire the result
  task automatic finish_out(input int stall);
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0; bus.in_valid = 1'($urandom); bus.mem_ack = 1'($urandom);
      @(posedge clk); #1;
      e_stall++;
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0; bus.mem_ack = 1'($urandom);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    set_idle();
  endtask

  initial begin
    logic [4:0] op_tab [16] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd6,
                                5'd6, 5'd7, 5'd9, 5'd10, 5'd10, 5'd10, 5'd8, 5'd31};
    int s0;
    n_checks = 0; n_errors = 0; chk_en = 1'b0; e_stall = 0;
    e_mem_wdata = '0; e_wb_result = '0; e_wb_rd = '0; e_wb_we = 1'b0; e_branch = '0;
    e_mem_addr = '0; e_mem_bank = '0; m_op = 5'd0; m_sd = '0; m_rdm = '0;
    set_idle();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mem_ack = 1'b0;
    scramble();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b0;
    chk_en = 1'b1;

    // ADD
    accept(5'd2, 32'h1234, $urandom, $urandom, 7'd5, 7'($urandom), 7'h11);
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_result", 64'(bus.wb_result), 64'h1234);
    check("add_rd", 64'(bus.wb_rd), 64'd5);
    check("add_we", 64'(bus.wb_we), 64'd1);
    finish_out(0);

    // CP to bank 1
    accept(5'd6, $urandom, 32'h0010_0004, $urandom, 7'($urandom), 7'h22, 7'h01);
    check("cp_bank", 64'(bus.mem_bank), 64'd1);
    check("cp_addr", 64'(bus.mem_addr), 64'h00004);
    check("cp_we", 64'(bus.mem_we), 64'd0);
    mem_phase(3, 32'hCAFE);
    check("cp_result", 64'(bus.wb_result), 64'hCAFE);
    check("cp_rd", 64'(bus.wb_rd), 64'h22);
    check("cp_wbwe", 64'(bus.wb_we), 64'd1);
    finish_out(0);

    // GP
    accept(5'd10, $urandom, 32'h0000_0123, 32'hBEEF, 7'($urandom), 7'h33, 7'h02);
    check("gp_we", 64'(bus.mem_we), 64'd1);
    check("gp_wdata", 64'(bus.mem_wdata), 64'hBEEF);
    mem_phase(2, $urandom);
    check("gp_wbwe", 64'(bus.wb_we), 64'd0);
    check("gp_result", 64'(bus.wb_result), 64'hBEEF);
    finish_out(1);

    // Downstream stall of 4 cycles
    accept(5'd3, 32'h55AA, $urandom, $urandom, 7'd9, 7'($urandom), 7'h03);
    s0 = e_stall;
    finish_out(4);
    check("stall_delta", 64'(e_stall - s0), 64'd4);

    // Reserved opcode
    accept(5'd7, 32'h77, $urandom, $urandom, 7'd4, 7'($urandom), 7'h04);
    check("rsv_valid", 64'(bus.out_valid), 64'd1);
    check("rsv_we", 64'(bus.wb_we), 64'd0);
    finish_out(0);
    check("rsv_idle", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of a store, then a late ack
    accept(5'd10, $urandom, $urandom, 32'hDEAD, 7'($urandom), 7'($urandom), 7'h05);
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    e_stall++;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    reset_checks("midmem");
    @(posedge clk); #1;
    rst = 1'b0;
    e_stall = 0;
    set_idle();
    chk_en = 1'b1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_idle", 64'(bus.out_valid), 64'd0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [4:0] op;
      op = op_tab[$urandom_range(0, 15)];
      repeat ($urandom_range(0, 2)) begin
        bus.mem_ack = 1'($urandom);
        @(posedge clk); #1;
      end
      accept(op, $urandom, $urandom, $urandom, 7'($urandom), 7'($urandom), 7'($urandom));
      if (op == 5'd6 || op == 5'd10) mem_phase($urandom_range(0, 4), $urandom);
      finish_out($urandom_range(0, 3));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
